xmem_arbiter: RTL

//  Shares the single external-memory port between up to four requesters (VDP, CPU, serloader,

---
 rtl/xmem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/xmem_arbiter.sv
// Fixed-priority arbiter sharing one external-memory port among NPORT requesters,
// with per-port starvation counters forcing a long-waiting port to the front.
module xmem_arbiter #(
    parameter int NPORT    = 4,
    parameter int MAX_WAIT = 3,
    parameter int WAIT_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NPORT-1:0]   req,
    input  logic [NPORT-1:0]   req_we,
    input  logic [NPORT*23-1:0] req_addr,
    input  logic [NPORT*16-1:0] req_wdata,
    input  logic [NPORT*2-1:0] req_be,
    output logic [NPORT-1:0]   ack,
    output logic [15:0]        rdata,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic               mem_req,
    output logic               mem_we,
    output logic [22:0]        mem_addr,
    output logic [15:0]        mem_wdata,
    output logic [1:0]         mem_be,
    input  logic               mem_ack,
    input  logic [15:0]        mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [NPORT-1:0]  pending_q, pending_d;
    logic [WAIT_W-1:0] wait_q [NPORT];
    logic [WAIT_W-1:0] wait_d [NPORT];
    logic [1:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [22:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [1:0]        be_q, be_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [NPORT-1:0]  ack_q, ack_d;

    logic [NPORT-1:0]  elig;
    logic [NPORT-1:0]  gmask;
    logic              have_win, starved;
    int unsigned       nwin, swin, win;

    always_comb begin
        elig     = pending_q | req;
        gmask    = '0;
        have_win = 1'b0;
        starved  = 1'b0;
        nwin     = 0;
        swin     = 0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (2'(i) == grant_q) gmask[i] = 1'b1;
            if (elig[i] && !have_win) begin
                have_win = 1'b1;
                nwin     = i;
            end
            if (elig[i] && !starved && wait_q[i] == WAIT_W'(MAX_WAIT)) begin
                starved = 1'b1;
                swin    = i;
            end
        end
        win = starved ? swin : nwin;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | req;
        wait_d    = wait_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        ack_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (have_win) begin
                    state_d   = S_ISSUE;
                    busy_d    = 1'b1;
                    mem_req_d = 1'b1;
                    grant_d   = 2'(win);
                    for (int unsigned i = 0; i < NPORT; i++) begin
                        if (i == win) begin
                            mem_we_d     = req_we[i];
                            addr_d       = req_addr[23*i +: 23];
                            wdata_d      = req_wdata[16*i +: 16];
                            be_d         = req_be[2*i +: 2];
                            pending_d[i] = 1'b0;
                            wait_d[i]    = '0;
                        end else if (elig[i] && wait_q[i] != WAIT_W'(MAX_WAIT)) begin
                            wait_d[i] = wait_q[i] + WAIT_W'(1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                // Re-requests from the owning port are absorbed until its DONE cycle.
                pending_d = pending_q | (req & ~gmask);
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) rdata_d = mem_rdata;
                    ack_d   = gmask;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            for (int unsigned i = 0; i < NPORT; i++) wait_q[i] <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '1;
            rdata_q   <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wait_q    <= wait_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule
